// File: rtl/kanagawa_memory_write_arbiter.sv
// Round-robin write-port arbiter with burst lock for a bypassed memory.
// Optional per-requester grant counters: KANAGAWA_WRITE_ARB_STATS_EN.
module kanagawa_memory_write_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int MAX_BURST      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQUESTERS-1:0]            req_valid_in,
    output logic [NUM_REQUESTERS-1:0]            req_ready_out,
    input  logic [NUM_REQUESTERS-1:0]            req_last_in,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr_in,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data_in,
    output logic                                 wren_out,
    output logic [ADDR_WIDTH-1:0]                write_addr_out,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic [$clog2(NUM_REQUESTERS)-1:0]    grant_id_out,
    output logic                                 locked_out,
    output logic                                 burst_overflow_out
`ifdef KANAGAWA_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQUESTERS*16-1:0]         grant_count_out
`endif
);

    localparam int ID_W  = $clog2(NUM_REQUESTERS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_nxt;
    logic [ID_W-1:0]  winner, sel;
    logic [ID_W:0]    idx;
    logic [CNT_W-1:0] count, count_nxt;
    logic             found, accept, acc_last, ovf_nxt;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;

    // Rotating priority scan starting at rr_ptr.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        idx    = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQUESTERS))
                idx = idx - (ID_W+1)'(NUM_REQUESTERS);
            if (!found && req_valid_in[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready_out = '0;
        sel = (state == LOCKED) ? owner : winner;
        if (rst) begin
            unique case (state)
                IDLE:   if (found) req_ready_out[winner] = 1'b1;
                LOCKED: req_ready_out[owner] = req_valid_in[owner];
                default: req_ready_out = '0;
            endcase
        end
        accept   = |(req_valid_in & req_ready_out);
        acc_last = req_last_in[sel];
        acc_addr = req_addr_in[sel*ADDR_WIDTH +: ADDR_WIDTH];
        acc_data = req_data_in[sel*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        count_nxt = count;
        rr_nxt    = rr_ptr;
        ovf_nxt   = burst_overflow_out;
        if (accept) begin
            if (count == CNT_W'(MAX_BURST))
                ovf_nxt = 1'b1;
            if (acc_last) begin
                state_nxt = IDLE;
                count_nxt = '0;
                rr_nxt = (sel == ID_W'(NUM_REQUESTERS-1)) ? '0 : sel + ID_W'(1);
            end else begin
                state_nxt = LOCKED;
                owner_nxt = sel;
                if (count != CNT_W'(MAX_BURST))
                    count_nxt = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= IDLE;
            owner              <= '0;
            count              <= '0;
            rr_ptr             <= '0;
            wren_out           <= 1'b0;
            write_addr_out     <= '0;
            data_out           <= '0;
            grant_id_out       <= '0;
            locked_out         <= 1'b0;
            burst_overflow_out <= 1'b0;
        end else begin
            state              <= state_nxt;
            owner              <= owner_nxt;
            count              <= count_nxt;
            rr_ptr             <= rr_nxt;
            wren_out           <= accept;
            locked_out         <= (state_nxt == LOCKED);
            burst_overflow_out <= ovf_nxt;
            if (accept) begin
                write_addr_out <= acc_addr;
                data_out       <= acc_data;
                grant_id_out   <= sel;
            end
        end
    end

`ifdef KANAGAWA_WRITE_ARB_STATS_EN
    logic [15:0] gcnt [NUM_REQUESTERS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQUESTERS; i++)
                gcnt[i] <= '0;
        end else if (accept && gcnt[sel] != 16'hFFFF) begin
            gcnt[sel] <= gcnt[sel] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_cnt
        assign grant_count_out[g*16 +: 16] = gcnt[g];
    end
`endif

endmodule
